// File: rtl/nn_wr_arbiter_if.sv
// Handshake bundle for the write-port arbiter: per-requester AW/W channels on one side,
// the shared bus AW/W channels and the sticky error flag on the other.
interface nn_wr_arbiter_if #(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = 28,
  parameter int DATA_W  = 32
);
  logic [NUM_REQ-1:0]          ReqArb_awvalid;
  logic [NUM_REQ*ADDR_W-1:0]   ReqArb_awaddr;
  logic [NUM_REQ*4-1:0]        ReqArb_awlen;
  logic [NUM_REQ*4-1:0]        ReqArb_awuser_id;
  logic [NUM_REQ-1:0]          ReqArb_awuser_ap;
  logic [NUM_REQ*DATA_W-1:0]   ReqArb_wdata;
  logic [NUM_REQ*DATA_W/8-1:0] ReqArb_wstrb;
  logic [NUM_REQ-1:0]          ArbReq_awready;
  logic [NUM_REQ-1:0]          ArbReq_wready;
  logic [NUM_REQ-1:0]          ArbReq_grant;

  logic                        BusArb_awready;
  logic                        BusArb_wready;
  logic                        BusArb_wuser_last;
  logic                        ArbBus_awvalid;
  logic [ADDR_W-1:0]           ArbBus_awaddr;
  logic [3:0]                  ArbBus_awlen;
  logic [3:0]                  ArbBus_awuser_id;
  logic                        ArbBus_awuser_ap;
  logic [DATA_W-1:0]           ArbBus_wdata;
  logic [DATA_W/8-1:0]         ArbBus_wstrb;
  logic                        Arb_err;

  modport slave (
    input  ReqArb_awvalid, ReqArb_awaddr, ReqArb_awlen, ReqArb_awuser_id, ReqArb_awuser_ap,
    input  ReqArb_wdata, ReqArb_wstrb,
    output ArbReq_awready, ArbReq_wready, ArbReq_grant,
    input  BusArb_awready, BusArb_wready, BusArb_wuser_last,
    output ArbBus_awvalid, ArbBus_awaddr, ArbBus_awlen, ArbBus_awuser_id, ArbBus_awuser_ap,
    output ArbBus_wdata, ArbBus_wstrb, Arb_err
  );

  modport master (
    output ReqArb_awvalid, ReqArb_awaddr, ReqArb_awlen, ReqArb_awuser_id, ReqArb_awuser_ap,
    output ReqArb_wdata, ReqArb_wstrb,
    input  ArbReq_awready, ArbReq_wready, ArbReq_grant,
    output BusArb_awready, BusArb_wready, BusArb_wuser_last,
    input  ArbBus_awvalid, ArbBus_awaddr, ArbBus_awlen, ArbBus_awuser_id, ArbBus_awuser_ap,
    input  ArbBus_wdata, ArbBus_wstrb, Arb_err
  );
endinterface

// File: rtl/nn_wr_arbiter.sv
// Round-robin write-port arbiter: one burst per grant, W path locked to the AW winner until
// its last beat. Pure mux plus sequencer, no data buffering.
module nn_wr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = 28,
  parameter int DATA_W  = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  nn_wr_arbiter_if.slave  arb
);
  localparam int IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int STRB_W = DATA_W / 8;

  typedef enum logic [1:0] {S_IDLE, S_AW, S_W} state_t;

  state_t             state;
  logic [NUM_REQ-1:0] grant;
  logic [IDX_W-1:0]   gidx;
  logic [IDX_W-1:0]   rr_ptr;
  logic [IDX_W-1:0]   next_ptr;
  logic [IDX_W-1:0]   pick_idx;
  logic [IDX_W-1:0]   cand;
  logic               pick_vld;
  logic [3:0]         len_q;
  logic [4:0]         beat_cnt;
  logic               err_q;
  logic               last_beat;
  int                 cand_sum;

  // Scan downward from the farthest candidate so the one nearest the pointer wins.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    cand_sum = 0;
    cand     = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand_sum = int'(rr_ptr) + k;
      if (cand_sum >= NUM_REQ) cand_sum = cand_sum - NUM_REQ;
      cand = IDX_W'(cand_sum);
      if (arb.ReqArb_awvalid[cand]) begin
        pick_vld = 1'b1;
        pick_idx = cand;
      end
    end
  end

  assign next_ptr  = (gidx == IDX_W'(NUM_REQ - 1)) ? '0 : gidx + 1'b1;
  assign last_beat = (beat_cnt == {1'b0, len_q});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      grant    <= '0;
      gidx     <= '0;
      rr_ptr   <= '0;
      len_q    <= '0;
      beat_cnt <= '0;
      err_q    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (pick_vld) begin
            grant <= NUM_REQ'(1) << pick_idx;
            gidx  <= pick_idx;
            len_q <= arb.ReqArb_awlen[int'(pick_idx)*4 +: 4];
            state <= S_AW;
          end
        end
        S_AW: begin
          if (!arb.ReqArb_awvalid[gidx]) begin
            grant <= '0;
            state <= S_IDLE;
          end else if (arb.BusArb_awready) begin
            beat_cnt <= '0;
            state    <= S_W;
          end
        end
        S_W: begin
          if (arb.BusArb_wready) begin
            // The bus last flag is only audited; the burst length is owned by the latched awlen.
            if (arb.BusArb_wuser_last != last_beat) err_q <= 1'b1;
            if (last_beat) begin
              grant    <= '0;
              rr_ptr   <= next_ptr;
              beat_cnt <= '0;
              state    <= S_IDLE;
            end else begin
              beat_cnt <= beat_cnt + 5'd1;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    arb.ArbBus_awvalid   = 1'b0;
    arb.ArbBus_awaddr    = '0;
    arb.ArbBus_awlen     = '0;
    arb.ArbBus_awuser_id = '0;
    arb.ArbBus_awuser_ap = 1'b0;
    arb.ArbBus_wdata     = '0;
    arb.ArbBus_wstrb     = '0;
    arb.ArbReq_awready   = '0;
    arb.ArbReq_wready    = '0;
    if (state == S_AW) begin
      arb.ArbBus_awvalid       = arb.ReqArb_awvalid[gidx];
      arb.ArbBus_awaddr        = arb.ReqArb_awaddr[int'(gidx)*ADDR_W +: ADDR_W];
      arb.ArbBus_awlen         = arb.ReqArb_awlen[int'(gidx)*4 +: 4];
      arb.ArbBus_awuser_id     = arb.ReqArb_awuser_id[int'(gidx)*4 +: 4];
      arb.ArbBus_awuser_ap     = arb.ReqArb_awuser_ap[gidx];
      arb.ArbReq_awready[gidx] = arb.BusArb_awready;
    end
    if (state == S_W) begin
      arb.ArbBus_wdata        = arb.ReqArb_wdata[int'(gidx)*DATA_W +: DATA_W];
      arb.ArbBus_wstrb        = arb.ReqArb_wstrb[int'(gidx)*STRB_W +: STRB_W];
      arb.ArbReq_wready[gidx] = arb.BusArb_wready;
    end
  end

  assign arb.ArbReq_grant = grant;
  assign arb.Arb_err      = err_q;
endmodule
